tdm_slot_scheduler: RTL and testbench

TDM_SLOT_SCHEDULER -- requirements
Module: tdm_slot_scheduler

---
 rtl/tdm_slot_scheduler.sv | 137 +++++++++++++
 tb/tb_tdm_slot_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_scheduler.sv
// TDM slot scheduler: steers an accepted serial bit stream onto a 1-to-4 demux,
// walking the enabled slots in ascending order for NUM_FRAMES frames per burst.
module tdm_slot_scheduler #(
   parameter int NUM_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] slot_en,
   input  logic       s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       in,
   output logic [1:0] sel,
   output logic       out_valid,
   output logic       frame_done,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_FRAME = 8'(NUM_FRAMES - 1);
   localparam logic [7:0] ALL_FRAMES = 8'(NUM_FRAMES);

   state_t     state;
   logic [3:0] mask_q;
   logic [1:0] ptr;
   logic [7:0] frame_cnt;

   function automatic logic [1:0] lo_slot(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (m[i]) r = 2'(i);
      return r;
   endfunction

   function automatic logic [1:0] hi_slot(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++)
         if (m[i]) r = 2'(i);
      return r;
   endfunction

   // Search upward from p+1 with wrap; a single-bit mask lands back on p.
   function automatic logic [1:0] next_slot(input logic [3:0] m,
                                            input logic [1:0] p);
      logic [1:0] r;
      logic       found;
      logic [1:0] idx;
      r     = p;
      found = 1'b0;
      for (int i = 1; i < 4; i++) begin
         idx = p + 2'(i);
         if (!found && m[idx]) begin
            r     = idx;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   logic accept;
   logic last_slot;
   logic last_beat;

   assign accept    = s_valid && s_ready;
   assign last_slot = (ptr == hi_slot(mask_q));
   assign last_beat = last_slot && (frame_cnt == LAST_FRAME);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         mask_q     <= 4'd0;
         ptr        <= 2'd0;
         frame_cnt  <= 8'd0;
         s_ready    <= 1'b0;
         in         <= 1'b0;
         sel        <= 2'd0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         in         <= 1'b0;
         frame_done <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (slot_en != 4'd0)) begin
                  state     <= RUN;
                  mask_q    <= slot_en;
                  ptr       <= lo_slot(slot_en);
                  frame_cnt <= 8'd0;
                  s_ready   <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  in        <= s_data;
                  sel       <= ptr;
                  ptr       <= next_slot(mask_q, ptr);
                  if (last_slot) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 8'd1;
                  end
                  if (last_beat) s_ready <= 1'b0;
               end
               // One drain cycle lets the final beat leave before done pulses.
               if (frame_cnt == ALL_FRAMES) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Bench for tdm_slot_scheduler: directed scenarios plus random traffic,
// compared every cycle against a burst-level reference model.
module tb_tdm_slot_scheduler;

   localparam int NF = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] slot_en = 4'd0;
   logic       s_data = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic       in;
   logic [1:0] sel;
   logic       out_valid;
   logic       frame_done;
   logic       busy;
   logic       done;

   tdm_slot_scheduler #(.NUM_FRAMES(NF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .slot_en    (slot_en),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .in         (in),
      .sel        (sel),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: 0 idle, 1 run, 2 drain, 3 done.
   int         mode = 0;
   int         order[$];
   int         k = 0;
   int         total = 0;
   logic       e_ready = 0, e_in = 0, e_ov = 0, e_fd = 0;
   logic       e_busy = 0, e_done = 0;
   logic [1:0] e_sel = 0;

   task automatic chk(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model();
      int n;
      e_ov   = 0;
      e_in   = 0;
      e_fd   = 0;
      e_done = 0;
      if (!rst_n) begin
         mode = 0; e_ready = 0; e_sel = 0; e_busy = 0;
         return;
      end
      case (mode)
         0: if (start && slot_en != 0) begin
            order.delete();
            for (int i = 0; i < 4; i++)
               if (slot_en[i]) order.push_back(i);
            k = 0;
            total = NF * order.size();
            mode = 1; e_ready = 1; e_busy = 1;
         end
         1: if (s_valid) begin
            n = order.size();
            e_ov  = 1;
            e_in  = s_data;
            e_sel = 2'(order[k % n]);
            e_fd  = ((k % n) == n - 1);
            k++;
            if (k == total) begin
               mode = 2; e_ready = 0;
            end
         end
         2: begin mode = 3; e_done = 1; end
         default: begin mode = 0; e_busy = 0; end
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model();
      chk("s_ready", {1'b0, s_ready}, {1'b0, e_ready});
      chk("in", {1'b0, in}, {1'b0, e_in});
      chk("sel", sel, e_sel);
      chk("out_valid", {1'b0, out_valid}, {1'b0, e_ov});
      chk("frame_done", {1'b0, frame_done}, {1'b0, e_fd});
      chk("busy", {1'b0, busy}, {1'b0, e_busy});
      chk("done", {1'b0, done}, {1'b0, e_done});
   endtask

   task automatic drv(input logic st, input logic [3:0] en,
                      input logic v, input logic d);
      start = st; slot_en = en; s_valid = v; s_data = d;
      cyc();
   endtask

   logic [7:0] pat;
   logic [3:0] va;

   initial begin
      rst_n = 0;
      drv(0, 4'hF, 1, 1);
      drv(0, 4'hF, 1, 1);
      rst_n = 1;

      // All slots, valid held, fixed payload.
      pat = 8'b0100_1101;
      drv(1, 4'hF, 0, 0);
      for (int i = 0; i < 8; i++) drv(0, 4'hF, 1, pat[i]);
      for (int i = 0; i < 4; i++) drv(0, 4'hF, 1, 1);

      // Empty mask is ignored.
      for (int i = 0; i < 3; i++) drv(1, 4'h0, 1, 1);

      // Sparse mask 1010.
      drv(1, 4'hA, 0, 0);
      for (int i = 0; i < 4; i++) drv(0, 4'hA, 1, i[0]);
      for (int i = 0; i < 3; i++) drv(0, 4'h0, 0, 0);

      // Valid gaps.
      drv(1, 4'hF, 0, 0);
      va = 4'b1001;
      for (int j = 0; j < 3; j++)
         for (int i = 3; i >= 0; i--) drv(0, 4'h0, va[i], 1);
      for (int i = 0; i < 6; i++) drv(0, 4'h0, 1, 1);

      // Reset after two beats, then restart at lowest slot.
      drv(1, 4'hE, 0, 0);
      drv(0, 4'h0, 1, 1);
      drv(0, 4'h0, 1, 1);
      rst_n = 0;
      drv(0, 4'h0, 1, 1);
      rst_n = 1;
      drv(0, 4'h0, 1, 1);
      drv(1, 4'hE, 0, 0);
      for (int i = 0; i < 10; i++) drv(0, 4'h0, 1, 0);

      // Mask change mid-run has no effect until next start.
      drv(1, 4'hF, 0, 0);
      for (int i = 0; i < 11; i++) drv(i == 3, 4'h1, 1, 1);
      drv(1, 4'h1, 0, 0);
      for (int i = 0; i < 5; i++) drv(0, 4'hF, 1, 0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         drv(1'($urandom_range(0, 3) == 0), 4'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom));
      end
      rst_n = 1;
      for (int i = 0; i < 20; i++) drv(0, 4'h0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
